// File: rtl/dmem_wait_responder_if.sv
// Purpose: data-memory bus between the CPU core (master) and the memory
//          responder (slave).
// Signals:
//   rd, wr      master -> slave  read / write request
//   abus        master -> slave  address (AW bits)
//   in_dbus     master -> slave  write data (DW bits)
//   out_dbus    slave -> master  registered read data
//   ready       slave -> master  idle/accepting, or read data valid
//   io_out      slave -> master  memory-mapped output latch
//   io_strobe   slave -> master  one-cycle pulse per output-latch write
//   err         slave -> master  one-cycle pulse on simultaneous rd+wr
interface dmem_wait_responder_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) ();
  logic          rd;
  logic          wr;
  logic [AW-1:0] abus;
  logic [DW-1:0] in_dbus;
  logic [DW-1:0] out_dbus;
  logic          ready;
  logic [DW-1:0] io_out;
  logic          io_strobe;
  logic          err;

  modport master (
    output rd, wr, abus, in_dbus,
    input  out_dbus, ready, io_out, io_strobe, err
  );

  modport slave (
    input  rd, wr, abus, in_dbus,
    output out_dbus, ready, io_out, io_strobe, err
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Purpose: data-memory responder for the simple CPU. 2**AW x DW storage that
//          reloads a fixed image on reset, registered reads with RD_LAT-1
//          wait states signalled through ready, and one memory-mapped output
//          latch at IO_ADDR.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset
//   bus   slave modport of dmem_wait_responder_if (rd/wr/abus/in_dbus in;
//         out_dbus/ready/io_out/io_strobe/err out, all registered)
module dmem_wait_responder #(
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned IO_ADDR = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_wait_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = $clog2(RD_LAT) + 1;

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] out_dbus_q, out_dbus_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] io_out_q, io_out_d;
  logic          io_strobe_q, io_strobe_d;
  logic          err_q, err_d;
  logic          mem_we_c;
  logic [DW-1:0] mem_q [DEPTH];

  // Storage; reset restores the boot image so an aborted program restarts clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      mem_q[1] <= DW'(8'h06);
      mem_q[2] <= DW'(8'h05);
    end else if (mem_we_c) begin
      mem_q[bus.abus] <= bus.in_dbus;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      out_dbus_q  <= '0;
      ready_q     <= 1'b1;
      io_out_q    <= '0;
      io_strobe_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      out_dbus_q  <= out_dbus_d;
      ready_q     <= ready_d;
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
      err_q       <= err_d;
    end
  end

  // Next-state and output logic. Writes win over reads; requests seen in
  // BUSY are dropped because the captured address alone drives the read.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    out_dbus_d  = out_dbus_q;
    ready_d     = ready_q;
    io_out_d    = io_out_q;
    io_strobe_d = 1'b0;
    err_d       = 1'b0;
    mem_we_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.wr) begin
          mem_we_c = 1'b1;
          if (bus.abus == AW'(IO_ADDR)) begin
            io_out_d    = bus.in_dbus;
            io_strobe_d = 1'b1;
          end
          err_d = bus.rd;
        end else if (bus.rd) begin
          if (RD_LAT <= 1) begin
            out_dbus_d = mem_q[bus.abus];
          end else begin
            addr_d  = bus.abus;
            cnt_d   = CW'(RD_LAT - 1);
            ready_d = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        // Last wait edge: present data and reopen the bus together.
        if (cnt_q == CW'(1)) begin
          out_dbus_d = mem_q[addr_q];
          ready_d    = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_dbus  = out_dbus_q;
  assign bus.ready     = ready_q;
  assign bus.io_out    = io_out_q;
  assign bus.io_strobe = io_strobe_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench: one responder with zero wait states and one with RD_LAT=3,
// sharing clock and reset.
module tb_dmem_wait_responder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  dmem_wait_responder_if #(.AW(5), .DW(8)) bus1 ();
  dmem_wait_responder_if #(.AW(5), .DW(8)) bus3 ();

  dmem_wait_responder #(.AW(5), .DW(8), .RD_LAT(1), .IO_ADDR(31)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  dmem_wait_responder #(.AW(5), .DW(8), .RD_LAT(3), .IO_ADDR(31)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    bus1.rd = 1'b0; bus1.wr = 1'b0; bus1.abus = '0; bus1.in_dbus = '0;
  endtask

  task automatic idle3();
    bus3.rd = 1'b0; bus3.wr = 1'b0; bus3.abus = '0; bus3.in_dbus = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    idle1();
    idle3();

    // Reset values
    #12;
    chk("rst_out1",    32'(bus1.out_dbus),  32'h00);
    chk("rst_ready1",  32'(bus1.ready),     32'h1);
    chk("rst_io1",     32'(bus1.io_out),    32'h00);
    chk("rst_strobe1", 32'(bus1.io_strobe), 32'h0);
    chk("rst_err1",    32'(bus1.err),       32'h0);
    chk("rst_ready3",  32'(bus3.ready),     32'h1);
    chk("rst_out3",    32'(bus3.out_dbus),  32'h00);
    rst = 1'b1;

    // 1: zero-wait read of image location 2
    bus1.rd = 1'b1; bus1.abus = 5'd2;
    chk("t1_ready_pre", 32'(bus1.ready), 32'h1);
    tick();
    chk("t1_out",   32'(bus1.out_dbus), 32'h05);
    chk("t1_ready", 32'(bus1.ready),    32'h1);
    idle1();

    // 2: RD_LAT=3 read of location 1
    bus3.rd = 1'b1; bus3.abus = 5'd1;
    tick();
    chk("t2_ready_e1", 32'(bus3.ready),    32'h0);
    chk("t2_out_e1",   32'(bus3.out_dbus), 32'h00);
    tick();
    chk("t2_ready_e2", 32'(bus3.ready),    32'h0);
    tick();
    chk("t2_ready_e3", 32'(bus3.ready),    32'h1);
    chk("t2_out_e3",   32'(bus3.out_dbus), 32'h06);
    idle3();

    // 3: ordinary write then read back
    bus1.wr = 1'b1; bus1.abus = 5'd3; bus1.in_dbus = 8'h0B;
    tick();
    chk("t3_strobe_w", 32'(bus1.io_strobe), 32'h0);
    chk("t3_ready_w",  32'(bus1.ready),     32'h1);
    bus1.wr = 1'b0; bus1.rd = 1'b1;
    tick();
    chk("t3_out",      32'(bus1.out_dbus),  32'h0B);
    chk("t3_strobe_r", 32'(bus1.io_strobe), 32'h0);
    chk("t3_io",       32'(bus1.io_out),    32'h00);
    idle1();

    // 4: output-latch write, strobe lasts exactly one cycle
    bus1.wr = 1'b1; bus1.abus = 5'd31; bus1.in_dbus = 8'hA5;
    tick();
    chk("t4_io",       32'(bus1.io_out),    32'hA5);
    chk("t4_strobe1",  32'(bus1.io_strobe), 32'h1);
    bus1.wr = 1'b0; bus1.rd = 1'b1;
    tick();
    chk("t4_strobe2",  32'(bus1.io_strobe), 32'h0);
    chk("t4_out",      32'(bus1.out_dbus),  32'hA5);
    chk("t4_io_hold",  32'(bus1.io_out),    32'hA5);
    idle1();

    // 5: simultaneous rd+wr: write only, error pulse, out_dbus unchanged
    bus1.rd = 1'b1; bus1.wr = 1'b1; bus1.abus = 5'd0; bus1.in_dbus = 8'h77;
    tick();
    chk("t5_err1",  32'(bus1.err),      32'h1);
    chk("t5_out1",  32'(bus1.out_dbus), 32'hA5);
    idle1();
    tick();
    chk("t5_err2",  32'(bus1.err),      32'h0);
    chk("t5_out2",  32'(bus1.out_dbus), 32'hA5);
    bus1.rd = 1'b1; bus1.abus = 5'd0;
    tick();
    chk("t5_rd0",   32'(bus1.out_dbus), 32'h77);
    chk("t5_io",    32'(bus1.io_out),   32'hA5);
    idle1();

    // Requests changed during BUSY are ignored and the write is dropped
    bus3.rd = 1'b1; bus3.abus = 5'd2;
    tick();
    bus3.abus = 5'd4; bus3.wr = 1'b1; bus3.in_dbus = 8'h99;
    tick();
    chk("busy_ready", 32'(bus3.ready), 32'h0);
    tick();
    chk("busy_out",   32'(bus3.out_dbus), 32'h05);
    chk("busy_rdy",   32'(bus3.ready),    32'h1);
    idle3();
    bus3.rd = 1'b1; bus3.abus = 5'd4;
    tick(); tick(); tick();
    chk("busy_drop",  32'(bus3.out_dbus), 32'h00);
    idle3();

    // 6: reset in the middle of a BUSY read
    bus3.wr = 1'b1; bus3.abus = 5'd3; bus3.in_dbus = 8'h44;
    tick();
    bus3.wr = 1'b0; bus3.rd = 1'b1;
    tick();
    chk("t6_busy",   32'(bus3.ready), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_ready",  32'(bus3.ready),    32'h1);
    chk("t6_out",    32'(bus3.out_dbus), 32'h00);
    chk("t6_io1",    32'(bus1.io_out),   32'h00);
    idle3();
    #1;
    rst = 1'b1;
    bus3.rd = 1'b1; bus3.abus = 5'd3;
    tick();
    chk("t6_rd_wait", 32'(bus3.ready), 32'h0);
    tick(); tick();
    chk("t6_rd_out",  32'(bus3.out_dbus), 32'h00);
    chk("t6_rd_rdy",  32'(bus3.ready),    32'h1);
    idle3();
    bus1.rd = 1'b1; bus1.abus = 5'd1;
    tick();
    chk("t6_image",   32'(bus1.out_dbus), 32'h06);
    idle1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
